// File: rtl/caravel_clock_ctrl.sv
// caravel_clock_ctrl: sequences a core clock reconfiguration so the clocking
// block never runs from an unstable PLL or sees a divider change on a live source.
// Order: park on external clock, start/stabilise the PLL, program the dividers,
// then switch to the target source. Runs on core_clk, which may change
// frequency during the sequence; each settle wait absorbs the switchover.
// Optional feature macro: CLK_CTRL_LOCK_TIMEOUT_EN adds pll_lock/err and
// replaces the fixed PLL wait with lock-or-timeout.
module caravel_clock_ctrl #(
  parameter int PLL_WAIT_CYCLES = 1024,
  parameter int SETTLE_CYCLES   = 16,
  parameter int CNT_W           = 12,
  parameter int TIMEOUT_CYCLES  = 4095
) (
  input  logic       core_clk,
  input  logic       resetb,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_ext_sel,
  input  logic [2:0] req_sel,
  input  logic [2:0] req_sel2,
  output logic       ext_clk_sel,
  output logic [2:0] sel,
  output logic [2:0] sel2,
  output logic       pll_ena,
  output logic       busy,
  output logic       done
`ifdef CLK_CTRL_LOCK_TIMEOUT_EN
  ,
  input  logic       pll_lock,
  output logic       err
`endif
);

`ifdef CLK_CTRL_LOCK_TIMEOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // PLL_WAIT bound: lock timeout when the lock input exists, fixed wait otherwise
  localparam int              WAIT_N    = LOCK_EN ? TIMEOUT_CYCLES : PLL_WAIT_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(WAIT_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, PARK, PLL_WAIT, DIV, SWITCH, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pll_stable;
  logic             t_ext;
  logic [2:0]       t_sel, t_sel2;

  // Sequencer: every output is set on the edge that enters its state, so each
  // wait state is loaded with N-1 and held exactly N cycles.
  always_ff @(posedge core_clk) begin
    if (!resetb) begin
      state       <= IDLE;
      cnt         <= '0;
      ext_clk_sel <= 1'b1;
      sel         <= 3'd0;
      sel2        <= 3'd0;
      pll_ena     <= 1'b0;
      pll_stable  <= 1'b0;
      done        <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      t_ext       <= 1'b1;
      t_sel       <= 3'd0;
      t_sel2      <= 3'd0;
`ifdef CLK_CTRL_LOCK_TIMEOUT_EN
      err         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            t_ext       <= req_ext_sel;
            t_sel       <= req_sel;
            t_sel2      <= req_sel2;
            state       <= PARK;
            cnt         <= SETTLE_LD;
            ext_clk_sel <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
`ifdef CLK_CTRL_LOCK_TIMEOUT_EN
            err         <= 1'b0;
`endif
          end
        end
        PARK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!t_ext && !pll_stable) begin
            state   <= PLL_WAIT;
            cnt     <= WAIT_LD;
            pll_ena <= 1'b1;
          end else begin
            state <= DIV;
            cnt   <= SETTLE_LD;
            sel   <= t_sel;
            sel2  <= t_sel2;
          end
        end
        PLL_WAIT: begin
`ifdef CLK_CTRL_LOCK_TIMEOUT_EN
          if (pll_lock) begin
            pll_stable <= 1'b1;
            state      <= DIV;
            cnt        <= SETTLE_LD;
            sel        <= t_sel;
            sel2       <= t_sel2;
          end else if (cnt == '0) begin
            // No lock: fall back to the external clock for the rest of the sequence
            err     <= 1'b1;
            t_ext   <= 1'b1;
            pll_ena <= 1'b0;
            state   <= DIV;
            cnt     <= SETTLE_LD;
            sel     <= t_sel;
            sel2    <= t_sel2;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
`else
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            pll_stable <= 1'b1;
            state      <= DIV;
            cnt        <= SETTLE_LD;
            sel        <= t_sel;
            sel2       <= t_sel2;
          end
`endif
        end
        DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state       <= SWITCH;
            cnt         <= SETTLE_LD;
            ext_clk_sel <= t_ext;
            if (t_ext) begin
              pll_ena    <= 1'b0;
              pll_stable <= 1'b0;
            end
          end
        end
        SWITCH: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
